// File: rtl/cia_interrupt_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cia_interrupt_ctrl_pkg
//   Shared types and constants for the CIA interrupt control register block.
//
//   model_t     : chip model selector (MOS6526 / MOS8521)
//   reg4_t      : register address type
//   reg8_t      : register data type
//   icr_src_t   : full-width (7 bit) interrupt source vector
//   latch_op_t  : {clear, set} request applied to the IR / IRQ latch
//   ICR_ADDR    : default register address of the ICR
//   lowest_set(): index of the lowest set bit of an icr_src_t (0 when none)
// ---------------------------------------------------------------------------
package cia_interrupt_ctrl_pkg;

    typedef enum logic {
        MOS6526 = 1'b0,
        MOS8521 = 1'b1
    } model_t;

    typedef logic [3:0] reg4_t;
    typedef logic [7:0] reg8_t;
    typedef logic [6:0] icr_src_t;

    // Encoding is {clr, ir_set}; the latch update decodes it directly.
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SET  = 2'b01,
        OP_CLR  = 2'b10,
        OP_RACE = 2'b11
    } latch_op_t;

    localparam reg4_t ICR_ADDR = 4'hD;

    // Lowest index wins; an empty vector yields 0 (qualified by a separate
    // valid bit at the use site).
    function automatic logic [2:0] lowest_set(input icr_src_t v);
        logic [2:0] id;
        logic       found;
        id    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (v[i] && !found) begin
                id    = i[2:0];
                found = 1'b1;
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/cia_interrupt_ctrl_src_delay.sv
// ---------------------------------------------------------------------------
// cia_src_delay
//   Parametrised-depth shift register for interrupt source pulses, advanced
//   once per phi2 cycle. DEPTH = 0 degenerates to a straight wire.
//
//   i_clk  : system clock
//   i_res  : synchronous active-high reset, clears every stage
//   i_en   : shift enable (phi2 rising-edge strobe)
//   i_d    : source pulses entering the pipe
//   o_q    : pipe tail (i_d delayed by DEPTH enabled cycles)
// ---------------------------------------------------------------------------
module cia_src_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = i_clk ^ i_res ^ i_en;
            assign o_q      = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_res) begin
                    for (int unsigned k = 0; k < DEPTH; k++) begin
                        r_pipe[k] <= '0;
                    end
                end else if (i_en) begin
                    r_pipe[0] <= i_d;
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end

            assign o_q = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/cia_interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// cia_interrupt_ctrl
//   CIA interrupt control register (ICR): latches up to 7 interrupt sources
//   into flags, gates them with a set/clear-written mask, drives the /IRQ
//   pad, returns the ICR read value and reports the lowest pending source.
//
//   i_clk        : system clock
//   i_res        : synchronous active-high reset
//   i_model      : chip model (MOS6526 uses the source delay pipe)
//   i_phi2_up    : one-clk strobe at phi2 rising edge
//   i_phi2_dn    : one-clk strobe at phi2 falling edge
//   i_rd / i_we  : bus read / write cycle
//   i_addr       : register address
//   i_data       : write data (bit 7 = set/clear, bits N_SRC-1:0 = mask bits)
//   i_sources    : interrupt source pulses
//   o_regs       : ICR read value {ir, zeros, flags}
//   o_irq_n      : /IRQ pad, active low
//   o_irq_id     : lowest pending-and-enabled source index (0 when none)
//   o_irq_id_vld : any (flags & mask) bit set
// ---------------------------------------------------------------------------
module cia_interrupt_ctrl
    import cia_interrupt_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC        = 5,
    parameter int unsigned DELAY_6526   = 1,
    parameter bit          LOSE_ON_READ = 1'b0,
    parameter logic [3:0]  ICR_ADDR     = cia_interrupt_ctrl_pkg::ICR_ADDR
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  model_t           i_model,
    input  logic             i_phi2_up,
    input  logic             i_phi2_dn,
    input  logic             i_rd,
    input  logic             i_we,
    input  logic [3:0]       i_addr,
    input  logic [7:0]       i_data,
    input  logic [N_SRC-1:0] i_sources,
    output logic [7:0]       o_regs,
    output logic             o_irq_n,
    output logic [2:0]       o_irq_id,
    output logic             o_irq_id_vld
);

    logic             w_addr_hit;
    logic [N_SRC-1:0] w_src_tail;
    logic [N_SRC-1:0] w_src_eff;
    logic             w_clr;
    logic [N_SRC-1:0] w_flags;
    logic [N_SRC-1:0] w_pend;
    logic             w_ir_set;
    logic             w_ir;
    logic             w_irq;
    icr_src_t         w_flags_ext;
    icr_src_t         w_pend_ext;
    logic             w_unused;

    logic             r_rd_flags;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_flags_q;
    logic             r_ir_q;
    logic             r_irq_q;

    // Only bit 7 and the low N_SRC data bits carry meaning.
    assign w_unused   = ^i_data;
    assign w_addr_hit = (i_addr == ICR_ADDR);

    // -----------------------------------------------------------------------
    // Source delay (6526 only). The pipe keeps running under either model so
    // a model change takes effect immediately without a flush.
    // -----------------------------------------------------------------------
    cia_src_delay #(
        .DEPTH (DELAY_6526),
        .WIDTH (N_SRC)
    ) u_src_delay (
        .i_clk (i_clk),
        .i_res (i_res),
        .i_en  (i_phi2_up),
        .i_d   (i_sources),
        .o_q   (w_src_tail)
    );

    assign w_src_eff = (i_model == MOS6526) ? w_src_tail : i_sources;

    // -----------------------------------------------------------------------
    // Read-clear strobe: one full phi2 cycle, from one phi2_dn to the next.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_rd_flags <= 1'b0;
        end else if (i_phi2_dn) begin
            r_rd_flags <= i_rd && w_addr_hit;
        end
    end

    assign w_clr = r_rd_flags | i_res;

    // -----------------------------------------------------------------------
    // Flags: combinational next value from the registered previous value.
    // Reset forces them clear regardless of the set/clear priority.
    // -----------------------------------------------------------------------
    always_comb begin
        w_flags = r_flags_q;
        if (i_res) begin
            w_flags = '0;
        end else if (LOSE_ON_READ) begin
            w_flags = w_clr ? '0 : (r_flags_q | w_src_eff);
        end else begin
            w_flags = w_src_eff | (w_clr ? '0 : r_flags_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_flags_q <= '0;
        end else begin
            r_flags_q <= w_flags;
        end
    end

    // -----------------------------------------------------------------------
    // Mask: bit 7 selects set (1) or clear (0) of the addressed bits.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_mask <= '0;
        end else if (i_phi2_dn && i_we && w_addr_hit) begin
            if (i_data[7]) begin
                r_mask <= r_mask | i_data[N_SRC-1:0];
            end else begin
                r_mask <= r_mask & ~i_data[N_SRC-1:0];
            end
        end
    end

    assign w_pend   = w_flags & r_mask;
    assign w_ir_set = |w_pend;

    // -----------------------------------------------------------------------
    // IR / IRQ latch. Outputs follow the current request combinationally;
    // the state only advances on phi2_up. On a coincident set and clear the
    // read value keeps IR set while the pad is released.
    // -----------------------------------------------------------------------
    always_comb begin
        w_ir  = r_ir_q;
        w_irq = r_irq_q;
        case (latch_op_t'({w_clr, w_ir_set}))
            OP_HOLD: begin
                w_ir  = r_ir_q;
                w_irq = r_irq_q;
            end
            OP_SET: begin
                w_ir  = 1'b1;
                w_irq = 1'b1;
            end
            OP_CLR: begin
                w_ir  = 1'b0;
                w_irq = 1'b0;
            end
            OP_RACE: begin
                w_ir  = 1'b1;
                w_irq = 1'b0;
            end
            default: begin
                w_ir  = r_ir_q;
                w_irq = r_irq_q;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_ir_q  <= 1'b0;
            r_irq_q <= 1'b0;
        end else if (i_phi2_up) begin
            r_ir_q  <= w_ir;
            r_irq_q <= w_irq;
        end
    end

    // -----------------------------------------------------------------------
    // Read value and debug index, widened to the full 7-bit source field.
    // -----------------------------------------------------------------------
    always_comb begin
        w_flags_ext              = '0;
        w_flags_ext[N_SRC-1:0]   = w_flags;
        w_pend_ext               = '0;
        w_pend_ext[N_SRC-1:0]    = w_pend;
    end

    assign o_regs       = {w_ir, w_flags_ext};
    assign o_irq_n      = ~w_irq;
    assign o_irq_id     = lowest_set(w_pend_ext);
    assign o_irq_id_vld = w_ir_set;

endmodule

// File: tb/tb_cia_interrupt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cia_interrupt_ctrl
//   Self-checking bench for cia_interrupt_ctrl. Three instances share all
//   inputs: inst 0 = defaults (DELAY 1, set-dominant), inst 1 = LOSE_ON_READ,
//   inst 2 = DELAY_6526 of 2. Expected values are queued when stimulus is
//   applied; observed values are queued at the sampling point and both
//   queues are compared at the end of each scenario task.
// ---------------------------------------------------------------------------
module tb_cia_interrupt_ctrl;
    import cia_interrupt_ctrl_pkg::*;

    localparam logic [12:0] ALL = '1;
    localparam logic [3:0]  ICR = 4'hD;

    logic       clk = 1'b0;
    logic [1:0] ph  = '0;
    logic       phi2_up;
    logic       phi2_dn;

    logic       res     = 1'b0;
    model_t     model   = MOS8521;
    logic       rd      = 1'b0;
    logic       we      = 1'b0;
    logic [3:0] addr    = ICR;
    logic [7:0] data    = '0;
    logic [4:0] sources = '0;

    logic [7:0] regs0, regs1, regs2;
    logic       irqn0, irqn1, irqn2;
    logic [2:0] id0, id1, id2;
    logic       vld0, vld1, vld2;

    always #5 clk = ~clk;
    always @(posedge clk) ph <= ph + 2'd1;
    assign phi2_up = (ph == 2'd0);
    assign phi2_dn = (ph == 2'd2);

    cia_interrupt_ctrl #(.N_SRC(5), .DELAY_6526(1), .LOSE_ON_READ(1'b0), .ICR_ADDR(4'hD)) u_dut (
        .i_clk(clk), .i_res(res), .i_model(model), .i_phi2_up(phi2_up), .i_phi2_dn(phi2_dn),
        .i_rd(rd), .i_we(we), .i_addr(addr), .i_data(data), .i_sources(sources),
        .o_regs(regs0), .o_irq_n(irqn0), .o_irq_id(id0), .o_irq_id_vld(vld0));

    cia_interrupt_ctrl #(.N_SRC(5), .DELAY_6526(1), .LOSE_ON_READ(1'b1), .ICR_ADDR(4'hD)) u_dut_lor (
        .i_clk(clk), .i_res(res), .i_model(model), .i_phi2_up(phi2_up), .i_phi2_dn(phi2_dn),
        .i_rd(rd), .i_we(we), .i_addr(addr), .i_data(data), .i_sources(sources),
        .o_regs(regs1), .o_irq_n(irqn1), .o_irq_id(id1), .o_irq_id_vld(vld1));

    cia_interrupt_ctrl #(.N_SRC(5), .DELAY_6526(2), .LOSE_ON_READ(1'b0), .ICR_ADDR(4'hD)) u_dut_d2 (
        .i_clk(clk), .i_res(res), .i_model(model), .i_phi2_up(phi2_up), .i_phi2_dn(phi2_dn),
        .i_rd(rd), .i_we(we), .i_addr(addr), .i_data(data), .i_sources(sources),
        .o_regs(regs2), .o_irq_n(irqn2), .o_irq_id(id2), .o_irq_id_vld(vld2));

    typedef struct {
        string       name;
        int          inst;
        logic [12:0] val;
        logic [12:0] care;
    } exp_t;

    exp_t        sb[$];
    logic [12:0] got[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Packed observation: {regs, irq_n, irq_id, irq_id_vld}
    function automatic logic [12:0] obs(input int inst);
        case (inst)
            0:       return {regs0, irqn0, id0, vld0};
            1:       return {regs1, irqn1, id1, vld1};
            default: return {regs2, irqn2, id2, vld2};
        endcase
    endfunction

    task automatic want(input string nm, input int inst, input logic [7:0] r, input logic n,
                        input logic [2:0] id, input logic v, input logic [12:0] care);
        exp_t e;
        e.name = nm; e.inst = inst; e.val = {r, n, id, v}; e.care = care;
        sb.push_back(e);
    endtask

    task automatic snap(input int inst);
        got.push_back(obs(inst));
    endtask

    task automatic next_up();
        @(negedge clk);
        while (!phi2_up) @(negedge clk);
    endtask

    task automatic next_dn();
        @(negedge clk);
        while (!phi2_dn) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b1; rd = 1'b0; we = 1'b0; sources = '0;
        repeat (2) @(negedge clk);
        res = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        next_dn();
        we = 1'b1; addr = a; data = d;
        @(negedge clk);
        we = 1'b0; addr = ICR; data = '0;
    endtask

    task automatic pulse_up(input logic [4:0] s);
        next_up();
        sources = s;
        @(negedge clk);
        sources = '0;
        #1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        exp_t e; logic [12:0] o;
        @(negedge clk);
        res = 1'b1;
        @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            want("reset_held", k, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(k);
        end
        res = 1'b0;
        repeat (5) @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            want("reset_idle", k, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(k);
        end
        while (sb.size() > 0 && got.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n_cmp++;
            if ((o & e.care) !== (e.val & e.care)) begin
                n_err++;
                $display("FAIL %s inst%0d: got %h required %h", e.name, e.inst, o & e.care, e.val & e.care);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_basic();
        exp_t e; logic [12:0] o;
        do_reset();
        model = MOS8521;
        bus_write(ICR, 8'h81);
        next_up();
        sources = 5'h01; #1;
        want("basic_same_cycle", 0, 8'h81, 1'b0, 3'd0, 1'b1, ALL); snap(0);
        @(negedge clk);
        sources = '0; #1;
        want("basic_held", 0, 8'h81, 1'b0, 3'd0, 1'b1, ALL); snap(0);
        next_dn();
        rd = 1'b1; addr = ICR; #1;
        want("basic_read_value", 0, 8'h81, 1'b0, 3'd0, 1'b1, ALL); snap(0);
        @(negedge clk);
        rd = 1'b0; #1;
        want("basic_cleared", 0, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(0);
        next_up(); @(negedge clk); #1;
        want("basic_next_phi2", 0, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(0);
        next_dn(); @(negedge clk); #1;
        want("basic_after_clr", 0, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(0);
        while (sb.size() > 0 && got.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n_cmp++;
            if ((o & e.care) !== (e.val & e.care)) begin
                n_err++;
                $display("FAIL %s inst%0d: got %h required %h", e.name, e.inst, o & e.care, e.val & e.care);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_delay();
        exp_t e; logic [12:0] o;
        model = MOS6526;
        do_reset();
        bus_write(ICR, 8'h82);
        next_up();
        sources = 5'h02; #1;
        want("delay1_src_cycle", 0, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(0);
        want("delay2_src_cycle", 2, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(2);
        @(negedge clk);
        sources = '0; #1;
        want("delay1_one_later", 0, 8'h82, 1'b0, 3'd1, 1'b1, ALL); snap(0);
        want("delay2_one_later", 2, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(2);
        next_up(); #1;
        want("delay2_before_edge", 2, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(2);
        @(negedge clk); #1;
        want("delay2_two_later", 2, 8'h82, 1'b0, 3'd1, 1'b1, ALL); snap(2);
        want("delay1_held", 0, 8'h82, 1'b0, 3'd1, 1'b1, ALL); snap(0);
        model = MOS8521;
        while (sb.size() > 0 && got.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n_cmp++;
            if ((o & e.care) !== (e.val & e.care)) begin
                n_err++;
                $display("FAIL %s inst%0d: got %h required %h", e.name, e.inst, o & e.care, e.val & e.care);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // The source lands on the last clk of the clear window, where set and
    // clear collide in the flag latch.
    task automatic test_read_race();
        exp_t e; logic [12:0] o;
        model = MOS8521;
        do_reset();
        bus_write(ICR, 8'h81);
        next_dn();
        rd = 1'b1; addr = ICR;
        @(negedge clk);
        rd = 1'b0;
        next_dn();
        sources = 5'h01; #1;
        want("race_sr_coincident", 0, 8'h81, 1'b1, 3'd0, 1'b1, ALL); snap(0);
        want("race_rs_coincident", 1, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(1);
        @(negedge clk);
        sources = '0; #1;
        want("race_sr_survives", 0, 8'h81, 1'b0, 3'd0, 1'b1, ALL); snap(0);
        want("race_rs_lost", 1, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(1);
        next_up(); @(negedge clk); #1;
        want("race_sr_latched", 0, 8'h81, 1'b0, 3'd0, 1'b1, ALL); snap(0);
        want("race_rs_latched", 1, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(1);
        while (sb.size() > 0 && got.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n_cmp++;
            if ((o & e.care) !== (e.val & e.care)) begin
                n_err++;
                $display("FAIL %s inst%0d: got %h required %h", e.name, e.inst, o & e.care, e.val & e.care);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_mask();
        exp_t e; logic [12:0] o;
        model = MOS8521;
        do_reset();
        pulse_up(5'h04);
        want("mask_off_flag", 0, 8'h04, 1'b1, 3'd0, 1'b0, ALL); snap(0);
        bus_write(4'hC, 8'h84);
        #1;
        want("mask_wrong_addr", 0, 8'h04, 1'b1, 3'd0, 1'b0, ALL); snap(0);
        bus_write(ICR, 8'h84);
        #1;
        want("mask_set", 0, 8'h84, 1'b0, 3'd2, 1'b1, ALL); snap(0);
        bus_write(ICR, 8'h04);
        #1;
        want("mask_clear_flag_kept", 0, 8'h04, 1'b0, 3'd0, 1'b0, 13'h0FEF); snap(0);
        next_dn();
        rd = 1'b1; addr = ICR;
        @(negedge clk);
        rd = 1'b0; #1;
        want("mask_read_release", 0, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(0);
        while (sb.size() > 0 && got.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n_cmp++;
            if ((o & e.care) !== (e.val & e.care)) begin
                n_err++;
                $display("FAIL %s inst%0d: got %h required %h", e.name, e.inst, o & e.care, e.val & e.care);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_priority();
        exp_t e; logic [12:0] o;
        model = MOS8521;
        do_reset();
        bus_write(ICR, 8'h8A);
        pulse_up(5'h08);
        want("prio_src3", 0, 8'h88, 1'b0, 3'd3, 1'b1, ALL); snap(0);
        pulse_up(5'h02);
        want("prio_src1_wins", 0, 8'h8A, 1'b0, 3'd1, 1'b1, ALL); snap(0);
        pulse_up(5'h01);
        want("prio_masked_low", 0, 8'h8B, 1'b0, 3'd1, 1'b1, ALL); snap(0);
        next_dn();
        rd = 1'b1; addr = ICR;
        @(negedge clk);
        rd = 1'b0; #1;
        want("prio_read_clear", 0, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(0);
        while (sb.size() > 0 && got.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n_cmp++;
            if ((o & e.care) !== (e.val & e.care)) begin
                n_err++;
                $display("FAIL %s inst%0d: got %h required %h", e.name, e.inst, o & e.care, e.val & e.care);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_mid_reset();
        exp_t e; logic [12:0] o;
        model = MOS8521;
        do_reset();
        bus_write(ICR, 8'h9F);
        pulse_up(5'h10);
        want("midres_active", 0, 8'h90, 1'b0, 3'd4, 1'b1, ALL); snap(0);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk); #1;
        want("midres_cleared", 0, 8'h00, 1'b1, 3'd0, 1'b0, ALL); snap(0);
        res = 1'b0;
        pulse_up(5'h01);
        want("midres_mask_zero", 0, 8'h01, 1'b1, 3'd0, 1'b0, ALL); snap(0);
        while (sb.size() > 0 && got.size() > 0) begin
            e = sb.pop_front(); o = got.pop_front(); n_cmp++;
            if ((o & e.care) !== (e.val & e.care)) begin
                n_err++;
                $display("FAIL %s inst%0d: got %h required %h", e.name, e.inst, o & e.care, e.val & e.care);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_delay();
        test_read_race();
        test_mask();
        test_priority();
        test_mid_reset();
        n_cmp++;
        if (sb.size() != 0 || got.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d/%0d left, required 0/0", sb.size(), got.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
